fetch_unit: RTL and testbench

Instruction fetch stage for the RV64I pipeline: owns the program counter and drives the instruction bus. Each returned 32-bit word, tagged with its PC, goes to the decode stage over a valid/ready handshake. Control-transfer redirects from execute (taken branch, JAL, JALR) are accepted here. An in-flight bus transaction is always completed on the bus and its data discarded when it belongs to the wrong path.

---
 rtl/common_pkg.sv | 17 +
 rtl/pipes_pkg.sv | 14 +
 rtl/fetch_unit.sv | 109 ++++++++++
 tb/tb_fetch_unit.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Shared constants and instruction-bus types used across the RV64I pipeline.
package common;

    localparam logic [63:0] PC_RESET_DEFAULT = 64'h0000_0000_8000_0000;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

endpackage

// File: rtl/pipes_pkg.sv
// Inter-stage payload types carried between pipeline stages.
package pipes;

    typedef struct packed {
        logic flush;
        logic stall;
    } control_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] raw_instr;
    } fetch_data_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one bus request at a time and
// hands each fetched word to decode; wrong-path responses are drained and dropped.
module fetch_unit
    import common::*;
    import pipes::*;
#(
    parameter logic [63:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output ibus_req_t   ireq,
    input  ibus_resp_t  iresp,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output fetch_data_t out
);

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DRAIN
    } fetch_state_t;

    fetch_state_t state, state_n;
    logic [63:0]  pc, pc_n;
    logic [63:0]  pending_pc, pending_pc_n;
    fetch_data_t  out_n;
    logic         out_valid_n;
    logic [63:0]  redirect_target;

    // Bus handshake only needs data_ok; address acceptance is not tracked.
    logic unused_addr_ok;
    assign unused_addr_ok = iresp.addr_ok;

    assign redirect_target = {redirect_pc[63:2], 2'b00};

    always_comb begin
        ireq       = '0;
        ireq.valid = !reset && (state != HOLD);
        ireq.addr  = pc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            pc         <= PC_RESET;
            pending_pc <= '0;
            out        <= '0;
            out_valid  <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            pending_pc <= pending_pc_n;
            out        <= out_n;
            out_valid  <= out_valid_n;
        end
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        pending_pc_n = pending_pc;
        out_n        = out;
        out_valid_n  = out_valid;
        unique case (state)
            FETCH: begin
                if (iresp.data_ok) begin
                    if (redirect_valid) begin
                        pc_n = redirect_target;
                    end else begin
                        out_n.pc        = pc;
                        out_n.raw_instr = iresp.data;
                        out_valid_n     = 1'b1;
                        state_n         = HOLD;
                    end
                end else if (redirect_valid) begin
                    pending_pc_n = redirect_target;
                    state_n      = DRAIN;
                end
            end
            HOLD: begin
                // A redirect wins over acceptance; the flushed word is wrong-path anyway.
                if (redirect_valid) begin
                    pc_n        = redirect_target;
                    out_valid_n = 1'b0;
                    state_n     = FETCH;
                end else if (out_ready) begin
                    pc_n        = pc + 64'd4;
                    out_valid_n = 1'b0;
                    state_n     = FETCH;
                end
            end
            DRAIN: begin
                if (iresp.data_ok) begin
                    pc_n    = redirect_valid ? redirect_target : pending_pc;
                    state_n = FETCH;
                end else if (redirect_valid) begin
                    pending_pc_n = redirect_target;
                end
            end
            default: begin
                state_n = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// bus/redirect/backpressure traffic compared against a transaction-level model.
module tb_fetch_unit;
    import common::*;
    import pipes::*;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    logic        clk;
    logic        reset;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    fetch_data_t out;

    int test_count;
    int fail_count;

    // Model: address being fetched, the buffered instruction (if any), and
    // whether the outstanding request is wrong-path plus where to go afterwards.
    logic [63:0] m_pc;
    logic        m_buf_valid;
    logic [95:0] m_buf;
    logic        m_discard;
    logic [63:0] m_target;

    fetch_unit #(.PC_RESET(RESET_PC)) dut (
        .clk           (clk),
        .reset         (reset),
        .ireq          (ireq),
        .iresp         (iresp),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out           (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [63:0] a);
        if (a == RESET_PC) return 32'h0000_0013;
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0000;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        test_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, let the
    // bus respond to whatever request is visible, then advance model and clock.
    task automatic applyStimulus(input logic rst, input logic rv, input logic [63:0] rpc,
                                 input logic rdy, input logic want_data);
        logic        dok;
        logic [63:0] tgt;
        reset          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        #1;
        checkOutput("req_valid", 128'(ireq.valid), 128'(!rst && !m_buf_valid));
        if (!rst && !m_buf_valid)
            checkOutput("req_addr", 128'(ireq.addr), 128'(m_pc));
        checkOutput("out_valid", 128'(out_valid), 128'(m_buf_valid));
        if (m_buf_valid) begin
            checkOutput("out_data", 128'(out), 128'(m_buf));
            checkOutput("out_word", 128'(out.raw_instr), 128'(memWord(out.pc)));
        end
        dok = want_data && ireq.valid;
        iresp.addr_ok = ireq.valid && ($urandom_range(0, 1) == 1);
        iresp.data_ok = dok;
        iresp.data    = memWord(ireq.addr);
        tgt = {rpc[63:2], 2'b00};
        if (rst) begin
            m_pc = RESET_PC; m_buf_valid = 1'b0; m_buf = '0; m_discard = 1'b0;
        end else if (m_buf_valid) begin
            if (rv) begin
                m_buf_valid = 1'b0; m_pc = tgt;
            end else if (rdy) begin
                m_buf_valid = 1'b0; m_pc = m_pc + 64'd4;
            end
        end else if (dok) begin
            if (m_discard) begin
                m_pc = rv ? tgt : m_target; m_discard = 1'b0;
            end else if (rv) begin
                m_pc = tgt;
            end else begin
                m_buf = {m_pc, memWord(m_pc)}; m_buf_valid = 1'b1;
            end
        end else if (rv) begin
            m_discard = 1'b1; m_target = tgt;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_count = 0;
        fail_count = 0;
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        iresp = '0;
        m_pc = RESET_PC; m_buf_valid = 1'b0; m_buf = '0; m_discard = 1'b0; m_target = '0;
        repeat (2) @(posedge clk);
        #1;

        applyStimulus(1'b1, 1'b0, 64'd0, 1'b0, 1'b0);
        checkOutput("reset_out", 128'(out), 128'd0);

        // First fetch with a single-cycle response, held in HOLD for 5 cycles.
        applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
        checkOutput("first_out", 128'({out_valid, out}),
                    128'({1'b1, 64'h8000_0000, 32'h0000_0013}));
        repeat (5) applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
        checkOutput("next_addr", 128'({ireq.valid, ireq.addr}), 128'({1'b1, 64'h8000_0004}));
        applyStimulus(1'b0, 1'b0, 64'd0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
        checkOutput("pc_plus8", 128'(ireq.addr), 128'(64'h8000_0008));

        // Redirect while the response is delayed: the old word must be dropped.
        applyStimulus(1'b0, 1'b1, 64'h8000_1000, 1'b1, 1'b0);
        repeat (2) applyStimulus(1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 64'd0, 1'b1, 1'b1);
        checkOutput("drain_target", 128'({out_valid, ireq.addr}), 128'({1'b0, 64'h8000_1000}));

        // Two redirects while draining; the later one wins.
        applyStimulus(1'b0, 1'b1, 64'h8000_2000, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 64'h8000_3000, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 64'd0, 1'b1, 1'b1);
        checkOutput("double_redirect", 128'(ireq.addr), 128'(64'h8000_3000));

        // Redirect coinciding with data_ok; low address bits are cleared.
        applyStimulus(1'b0, 1'b1, 64'h8000_0103, 1'b1, 1'b1);
        checkOutput("redirect_dataok", 128'({out_valid, ireq.addr}), 128'({1'b0, 64'h8000_0100}));

        // Reset while draining abandons the request.
        applyStimulus(1'b0, 1'b1, 64'h8000_4000, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 64'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
        checkOutput("reset_in_drain", 128'({ireq.valid, ireq.addr}), 128'({1'b1, RESET_PC}));

        // PC wraps from the top of the address space to zero.
        applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
        checkOutput("wrap_zero", 128'({ireq.valid, ireq.addr}), 128'({1'b1, 64'd0}));

        for (int i = 0; i < 3000; i++) begin
            logic [63:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15)))
                                              : {$urandom, $urandom};
            applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 5) == 0, rpc,
                          $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
